// File: rtl/disp_cmd_buffer_pkg.sv
// Shared definitions for the dispatcher command buffer: field indices, command
// layout and bit offsets also used by the channel controller.
package disp_cmd_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int HALF_WIDTH = 16;
    localparam int NUM_FIELDS = 4;
    localparam int CMD_WIDTH  = NUM_FIELDS * (WORD_WIDTH + HALF_WIDTH);

    localparam logic [1:0] W_ROW     = 2'd0;
    localparam logic [1:0] W_COL     = 2'd1;
    localparam logic [1:0] W_HOSTBUF = 2'd2;
    localparam logic [1:0] W_TAG     = 2'd3;
    localparam logic [1:0] H_OPCODE  = 2'd0;
    localparam logic [1:0] H_WAY     = 2'd1;
    localparam logic [1:0] H_SRCID   = 2'd2;
    localparam logic [1:0] H_LEN     = 2'd3;

    // Half-words occupy the low 64 bits, words sit above them.
    localparam int H_OPCODE_LSB  = 0;
    localparam int H_WAY_LSB     = 16;
    localparam int H_SRCID_LSB   = 32;
    localparam int H_LEN_LSB     = 48;
    localparam int W_ROW_LSB     = 64;
    localparam int W_COL_LSB     = 96;
    localparam int W_HOSTBUF_LSB = 128;
    localparam int W_TAG_LSB     = 160;

    typedef logic [NUM_FIELDS-1:0][WORD_WIDTH-1:0] wordBank_t;
    typedef logic [NUM_FIELDS-1:0][HALF_WIDTH-1:0] halfBank_t;
    typedef logic [CMD_WIDTH-1:0]                  cmd_t;

    function automatic cmd_t packCmd(input wordBank_t words, input halfBank_t halves);
        return {words, halves};
    endfunction

endpackage

// File: rtl/disp_cmd_buffer_if.sv
// Buffer-write / issue / drain signal bundle between the dispatcher core,
// the command buffer and the downstream channel controller.
interface disp_cmd_buffer_if #(
    parameter int COUNT_WIDTH = 3
);
    import disp_cmd_pkg::*;

    logic [1:0]             iBufWriteAddress;
    logic [WORD_WIDTH-1:0]  iBufWordWriteData;
    logic [HALF_WIDTH-1:0]  iBufHalfWordWriteData;
    logic                   iBufWordWriteValid;
    logic                   iBufHalfWordWriteValid;
    logic                   iBufIssueCmdValid;
    logic                   oBufIssueCmdReady;
    logic                   oCmdValid;
    logic                   iCmdReady;
    logic [CMD_WIDTH-1:0]   oCmdData;
    logic [COUNT_WIDTH-1:0] oQueueCount;

    modport master (
        output iBufWriteAddress, iBufWordWriteData, iBufHalfWordWriteData,
               iBufWordWriteValid, iBufHalfWordWriteValid, iBufIssueCmdValid, iCmdReady,
        input  oBufIssueCmdReady, oCmdValid, oCmdData, oQueueCount
    );

    modport slave (
        input  iBufWriteAddress, iBufWordWriteData, iBufHalfWordWriteData,
               iBufWordWriteValid, iBufHalfWordWriteValid, iBufIssueCmdValid, iCmdReady,
        output oBufIssueCmdReady, oCmdValid, oCmdData, oQueueCount
    );

endinterface

// File: rtl/disp_cmd_buffer_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head data comes straight
// from registered storage.
module disp_cmd_fifo #(
    parameter int WIDTH       = 192,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [COUNT_WIDTH-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             doPush, doPop;

    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty_o = (wptr_q == rptr_q);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    always_comb begin
        wptr_d = doPush ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = doPop  ? rptr_q + PTR_ONE : rptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (doPush) begin
                mem_q[wptr_q[AW-1:0]] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign count_o = COUNT_WIDTH'(wptr_q - rptr_q);

endmodule

// File: rtl/disp_cmd_buffer.sv
// Staging register bank plus issue queue; an issue snapshots the bank, with
// same-cycle field writes merged in, into the command FIFO.
module disp_cmd_buffer
    import disp_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int COUNT_WIDTH = 3
) (
    input  logic            iClock,
    input  logic            iReset,
    disp_cmd_buffer_if.slave bus
);

    wordBank_t wordBank_q, wordBank_d;
    halfBank_t halfBank_q, halfBank_d;
    cmd_t      pushData;
    logic      full, empty, push, pop;

    // Merged view of the bank: feeds both the register and the issue snapshot.
    always_comb begin
        wordBank_d = wordBank_q;
        halfBank_d = halfBank_q;
        if (bus.iBufWordWriteValid) begin
            wordBank_d[bus.iBufWriteAddress] = bus.iBufWordWriteData;
        end
        if (bus.iBufHalfWordWriteValid) begin
            halfBank_d[bus.iBufWriteAddress] = bus.iBufHalfWordWriteData;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            wordBank_q <= '0;
            halfBank_q <= '0;
        end else begin
            wordBank_q <= wordBank_d;
            halfBank_q <= halfBank_d;
        end
    end

    assign pushData = packCmd(wordBank_d, halfBank_d);
    assign push     = bus.iBufIssueCmdValid && !full;
    assign pop      = bus.iCmdReady && !empty;

    disp_cmd_fifo #(
        .WIDTH       (CMD_WIDTH),
        .DEPTH       (FIFO_DEPTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_fifo (
        .clk_i   (iClock),
        .rst_i   (iReset),
        .push_i  (push),
        .data_i  (pushData),
        .pop_i   (pop),
        .data_o  (bus.oCmdData),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.oQueueCount)
    );

    assign bus.oBufIssueCmdReady = !full;
    assign bus.oCmdValid         = !empty;

endmodule
